// File: rtl/cube_table_gen.sv
// ----------------------------------------------------------------------------
// cube_table_gen
//
// Purpose:
//   Fills an internal DEPTH-entry table with consecutive cubes n^3, where
//   n = first .. first+count-1. The cubes are produced by finite differences,
//   so the datapath uses only adders. Values that do not fit in WIDTH bits
//   either saturate or wrap, depending on the mode chosen for that run. A
//   sticky overflow flag records that this happened. The table is read back
//   through a registered read port.
//
// Parameters:
//   WIDTH   stored word width, also the width of first_i
//   DEPTH   number of table entries
//   AW      read address width, 2**AW >= DEPTH
//
// Ports:
//   clk_i      single clock, rising edge
//   rst_ni     asynchronous active-low reset; clears the FSM and the table
//   start_i    run request, accepted only while idle
//   first_i    first n of the run
//   count_i    number of entries to write, clamped to DEPTH
//   sat_i      1 = saturate to 2**WIDTH-1, 0 = keep the low WIDTH bits
//   rd_addr_i  table read address
//   rd_data_o  registered table word; 0 for addresses >= DEPTH
//   busy_o     high while skipping to first or filling the table
//   done_o     one-cycle pulse at the end of a run
//   ovf_o      sticky overflow, cleared by the next accepted start
// ----------------------------------------------------------------------------
module cube_table_gen #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] first_i,
    input  logic [AW:0]      count_i,
    input  logic             sat_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o
);

    // Difference registers are sized so that c = n^3 cannot overflow for
    // any n reachable by a run (n <= 2**WIDTH - 1 + DEPTH).
    localparam int          IW      = 3 * (WIDTH + 1) + 3;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        FILL,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    n_q, n_d;
    logic [IW-1:0]    c_q, c_d;
    logic [IW-1:0]    a_q, a_d;
    logic [IW-1:0]    b_q, b_d;
    logic [WIDTH-1:0] first_q, first_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [AW:0]      k_q, k_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    // Next values of the finite-difference chain. They keep
    // c = n^3, a = 3n^2+3n+1 and b = 6n+6 true after every step.
    logic [IW-1:0]    n_step, c_step, a_step, b_step;
    logic             c_too_big;
    logic [WIDTH-1:0] store_val;
    logic             skip_last;
    logic             fill_last;
    logic [AW:0]      count_clamped;
    logic             rd_in_range;

    assign n_step = n_q + IW'(1);
    assign c_step = c_q + a_q;
    assign a_step = a_q + b_q;
    assign b_step = b_q + IW'(6);

    // A cube needs more than WIDTH bits as soon as any upper bit is set.
    assign c_too_big = |c_q[IW-1:WIDTH];
    assign store_val = (c_too_big && sat_q) ? {WIDTH{1'b1}} : c_q[WIDTH-1:0];

    // SKIP stops on the step that brings n up to first. FILL stops after
    // writing the last requested entry.
    assign skip_last = (n_step == IW'(first_q));
    assign fill_last = (k_q == cnt_q - (AW + 1)'(1));

    assign count_clamped = (count_i > DEPTH_C) ? DEPTH_C : count_i;
    assign rd_in_range   = ({1'b0, rd_addr_i} < DEPTH_C);

    assign busy_o    = (state_q == SKIP) || (state_q == FILL);
    assign done_o    = (state_q == DONE);
    assign ovf_o     = ovf_q;
    assign rd_data_o = rd_data_q;

    // Next-state and datapath control. Every signal gets its hold value
    // first. Each state then overrides only what it changes.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        c_d     = c_q;
        a_d     = a_q;
        b_d     = b_q;
        first_d = first_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        k_d     = k_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_addr = k_q[AW-1:0];
        wr_data = store_val;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    first_d = first_i;
                    cnt_d   = count_clamped;
                    sat_d   = sat_i;
                    ovf_d   = 1'b0;
                    n_d     = '0;
                    c_d     = '0;
                    a_d     = IW'(1);
                    b_d     = IW'(6);
                    k_d     = '0;
                    if (first_i != '0) begin
                        state_d = SKIP;
                    end else if (count_clamped != '0) begin
                        state_d = FILL;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            SKIP: begin
                n_d = n_step;
                c_d = c_step;
                a_d = a_step;
                b_d = b_step;
                if (skip_last) begin
                    state_d = (cnt_q != '0) ? FILL : DONE;
                end
            end

            FILL: begin
                wr_en = 1'b1;
                if (c_too_big) begin
                    ovf_d = 1'b1;
                end
                n_d = n_step;
                c_d = c_step;
                a_d = a_step;
                b_d = b_step;
                k_d = k_q + (AW + 1)'(1);
                if (fill_last) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data is selected from the current table contents. A read of the
    // entry being written in the same cycle therefore returns the old word.
    always_comb begin
        rd_data_d = '0;
        if (rd_in_range) begin
            rd_data_d = mem_q[rd_addr_i];
        end
    end

    // FSM state, latched run parameters and difference registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            n_q     <= '0;
            c_q     <= '0;
            a_q     <= IW'(1);
            b_q     <= IW'(6);
            first_q <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            k_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            k_q     <= k_d;
            ovf_q   <= ovf_d;
        end
    end

    // Table storage and the registered read port. Reset clears every entry,
    // so a run cut short by reset leaves nothing behind.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_addr] <= wr_data;
            end
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_cube_table_gen.sv
// ----------------------------------------------------------------------------
// tb_cube_table_gen
//
// Self-checking bench for cube_table_gen (WIDTH=8, DEPTH=16, AW=4).
// A reference table is rebuilt from direct n*n*n arithmetic whenever a run
// is launched. Reads push the expected word into a queue. A monitor pops
// that word and compares it once the registered read data is available.
// ----------------------------------------------------------------------------
module tb_cube_table_gen;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk_i     = 1'b0;
    logic             rst_ni    = 1'b0;
    logic             start_i   = 1'b0;
    logic [WIDTH-1:0] first_i   = '0;
    logic [AW:0]      count_i   = '0;
    logic             sat_i     = 1'b0;
    logic [AW-1:0]    rd_addr_i = '0;
    logic [WIDTH-1:0] rd_data_o;
    logic             busy_o;
    logic             done_o;
    logic             ovf_o;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model [DEPTH];
    logic             modelOvf = 1'b0;

    logic [WIDTH-1:0] expQ[$];
    int               addrQ[$];
    bit               rdValid = 1'b0;
    logic [WIDTH-1:0] monExp;
    int               monAddr;

    cube_table_gen #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .first_i  (first_i),
        .count_i  (count_i),
        .sat_i    (sat_i),
        .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard monitor: each read issued before an edge is checked 1 ns
    // after that edge against the word queued when it was issued.
    always begin
        @(posedge clk_i);
        if (rdValid) begin
            #1;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL rd_scoreboard_underflow got %0d want queued entry", rd_data_o);
            end else begin
                monExp  = expQ.pop_front();
                monAddr = addrQ.pop_front();
                if (rd_data_o !== monExp) begin
                    errors++;
                    $display("[TB] FAIL rd_data[%0d] got %0d want %0d", monAddr, rd_data_o, monExp);
                end
            end
        end
    end

    // Global watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Issue reads for addresses lo..hi on consecutive cycles and queue the
    // reference words.
    task automatic readRange(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            @(negedge clk_i);
            rd_addr_i = a[AW-1:0];
            rdValid   = 1'b1;
            expQ.push_back(model[a]);
            addrQ.push_back(a);
        end
        @(negedge clk_i);
        rdValid = 1'b0;
        @(negedge clk_i);
    endtask

    // Start a run, update the reference table and measure its timing.
    // When noisy is set, the task pulses start and scrambles inputs while
    // the run is in progress and in the done cycle.
    task automatic launch(input int f, input int c, input bit s, input bit noisy,
                          output int busyCycles, output int doneAt, output int doneCount);
        int     cl;
        longint n;
        longint v;
        @(negedge clk_i);
        first_i = f[WIDTH-1:0];
        count_i = c[AW:0];
        sat_i   = s;
        start_i = 1'b1;
        cl       = (c > DEPTH) ? DEPTH : c;
        modelOvf = 1'b0;
        for (int k = 0; k < cl; k++) begin
            n = longint'(f + k);
            v = n * n * n;
            if (v > 255) begin
                modelOvf = 1'b1;
                model[k] = s ? 8'hFF : v[WIDTH-1:0];
            end else begin
                model[k] = v[WIDTH-1:0];
            end
        end
        @(negedge clk_i);
        start_i    = 1'b0;
        busyCycles = 0;
        doneAt     = -1;
        doneCount  = 0;
        for (int i = 1; i <= 300; i++) begin
            if (busy_o === 1'b1) busyCycles++;
            if (done_o === 1'b1) begin
                doneCount++;
                if (doneAt < 0) doneAt = i;
            end
            if (noisy) begin
                start_i = (i == 2) || (done_o === 1'b1);
                first_i = WIDTH'($urandom);
                count_i = (AW + 1)'($urandom);
                sat_i   = 1'($urandom);
            end
            if (doneAt >= 0 && done_o !== 1'b1) break;
            @(negedge clk_i);
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy_o); end
        checks++;
        if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done_o); end
        checks++;
        if (ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b want 0", ovf_o); end
        checks++;
        if (rd_data_o !== '0) begin errors++; $display("[TB] FAIL reset_rd_data got %0d want 0", rd_data_o); end
        rst_ni = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        readRange(0, DEPTH - 1);
    endtask

    task automatic test_basic();
        int bc, da, dc;
        launch(0, 6, 1'b0, 1'b0, bc, da, dc);
        checks++;
        if (bc != 6) begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d want 6", bc); end
        checks++;
        if (da != 7) begin errors++; $display("[TB] FAIL basic_done_at got %0d want 7", da); end
        checks++;
        if (dc != 1) begin errors++; $display("[TB] FAIL basic_done_pulses got %0d want 1", dc); end
        checks++;
        if (ovf_o !== modelOvf) begin errors++; $display("[TB] FAIL basic_ovf got %b want %b", ovf_o, modelOvf); end
        readRange(0, DEPTH - 1);
    endtask

    task automatic test_offset_sat();
        int bc, da, dc;
        launch(5, 3, 1'b1, 1'b0, bc, da, dc);
        checks++;
        if (da != 9) begin errors++; $display("[TB] FAIL sat_done_at got %0d want 9", da); end
        checks++;
        if (bc != 8) begin errors++; $display("[TB] FAIL sat_busy_cycles got %0d want 8", bc); end
        checks++;
        if (ovf_o !== 1'b1) begin errors++; $display("[TB] FAIL sat_ovf got %b want 1", ovf_o); end
        readRange(0, 3);
    endtask

    task automatic test_offset_wrap();
        int bc, da, dc;
        launch(5, 3, 1'b0, 1'b0, bc, da, dc);
        checks++;
        if (ovf_o !== 1'b1) begin errors++; $display("[TB] FAIL wrap_ovf got %b want 1", ovf_o); end
        checks++;
        if (model[2] !== 8'd87) begin errors++; $display("[TB] FAIL wrap_model_entry got %0d want 87", model[2]); end
        readRange(0, 3);
        launch(0, 1, 1'b0, 1'b0, bc, da, dc);
        checks++;
        if (ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL wrap_ovf_cleared got %b want 0", ovf_o); end
        checks++;
        if (da != 2) begin errors++; $display("[TB] FAIL wrap_followup_done_at got %0d want 2", da); end
        readRange(0, 3);
    endtask

    task automatic test_clamp();
        int bc, da, dc;
        launch(0, 20, 1'b0, 1'b0, bc, da, dc);
        checks++;
        if (bc != 16) begin errors++; $display("[TB] FAIL clamp_busy_cycles got %0d want 16", bc); end
        checks++;
        if (da != 17) begin errors++; $display("[TB] FAIL clamp_done_at got %0d want 17", da); end
        checks++;
        if (ovf_o !== 1'b1) begin errors++; $display("[TB] FAIL clamp_ovf got %b want 1", ovf_o); end
        readRange(0, DEPTH - 1);
        launch(0, 0, 1'b0, 1'b0, bc, da, dc);
        checks++;
        if (da != 1) begin errors++; $display("[TB] FAIL empty_done_at got %0d want 1", da); end
        checks++;
        if (bc != 0) begin errors++; $display("[TB] FAIL empty_busy_cycles got %0d want 0", bc); end
        checks++;
        if (ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL empty_ovf got %b want 0", ovf_o); end
        readRange(15, 15);
        readRange(0, DEPTH - 1);
    endtask

    task automatic test_ignored_start();
        int bc, da, dc;
        launch(3, 4, 1'b0, 1'b1, bc, da, dc);
        checks++;
        if (da != 8) begin errors++; $display("[TB] FAIL ignored_done_at got %0d want 8", da); end
        checks++;
        if (bc != 7) begin errors++; $display("[TB] FAIL ignored_busy_cycles got %0d want 7", bc); end
        checks++;
        if (dc != 1) begin errors++; $display("[TB] FAIL ignored_done_pulses got %0d want 1", dc); end
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL ignored_no_restart got %b want 0", busy_o); end
        checks++;
        if (ovf_o !== modelOvf) begin errors++; $display("[TB] FAIL ignored_ovf got %b want %b", ovf_o, modelOvf); end
        readRange(0, DEPTH - 1);
    endtask

    task automatic test_reset_mid_run();
        int bc, da, dc;
        @(negedge clk_i);
        first_i = 8'd5;
        count_i = 5'd8;
        sat_i   = 1'b0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (8) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL midrun_busy_before got %b want 1", busy_o); end
        checks++;
        if (ovf_o !== 1'b1) begin errors++; $display("[TB] FAIL midrun_ovf_before got %b want 1", ovf_o); end
        checks++;
        if (rd_data_o !== model[15]) begin errors++; $display("[TB] FAIL midrun_rd_before got %0d want %0d", rd_data_o, model[15]); end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midrun_busy got %b want 0", busy_o); end
        checks++;
        if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL midrun_done got %b want 0", done_o); end
        checks++;
        if (ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL midrun_ovf got %b want 0", ovf_o); end
        checks++;
        if (rd_data_o !== '0) begin errors++; $display("[TB] FAIL midrun_rd_data got %0d want 0", rd_data_o); end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        readRange(0, DEPTH - 1);
        launch(2, 5, 1'b1, 1'b0, bc, da, dc);
        checks++;
        if (da != 8) begin errors++; $display("[TB] FAIL fresh_done_at got %0d want 8", da); end
        checks++;
        if (ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL fresh_ovf got %b want 0", ovf_o); end
        readRange(0, DEPTH - 1);
    endtask

    initial begin
        $display("[TB] cube_table_gen bench starting");
        test_reset();
        test_basic();
        test_offset_sat();
        test_offset_wrap();
        test_clamp();
        test_ignored_start();
        test_reset_mid_run();
        repeat (2) @(negedge clk_i);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cube_table_gen.md
# cube_table_gen

Parametrised cube-table engine. On `start` it generates consecutive cubes n³ for n = `first` … `first`+`count`−1 using finite differences, so no multiplier is needed. Results go into an internal DEPTH-entry table, with per-run wrap or saturate handling of overflow. It sits beside the cube datapath under `top`, which reads the table back through a registered read port instead of fixed per-word outputs.

## Interface
- `WIDTH`, 8: stored word width; `first` width.
- `DEPTH`, 16: table entries.
- `AW`, 4: address width; must satisfy 2^AW ≥ DEPTH.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  run request, sampled only in IDLE.
- `first`  in  WIDTH  first n of the run.
- `count`  in  AW+1  entries to write; values > DEPTH are clamped to DEPTH.
- `sat`  in  1  1 = saturate to 2^WIDTH−1, 0 = keep low WIDTH bits (wrap).
- `rd_addr`  in  AW  table read address.
- `rd_data`  out  WIDTH  registered table word.
- `busy`  out  1  high in SKIP and FILL.
- `done`  out  1  one-cycle pulse at run end.
- `ovf`  out  1  sticky: some stored value exceeded 2^WIDTH−1; cleared by the next accepted `start`.

## Operation
- **States:** IDLE, SKIP, FILL, DONE.
- **IDLE, `start`=1:**
  - Latch `first`, clamped `count` and `sat`.
  - Clear `ovf`.
  - Load n=0, c=0, a=1, b=6.
  - Next state is SKIP if `first`>0, else FILL if count>0, else DONE.
- **Difference update** (every SKIP and FILL cycle):
  - c←c+a, a←a+b, b←b+6, n←n+1.
  - Invariant: c=n³, a=3n²+3n+1, b=6n+6.
  - Internal width is 3·(WIDTH+1)+3 bits. This never overflows for n ≤ 2^WIDTH−1+DEPTH.
- **SKIP:**
  - Update only, no write.
  - Leave when n+1 = `first`: go to FILL if count>0, else DONE.
- **FILL:**
  - Write table[k] ← store(c) with k = 0,1,…, then update.
  - Leave to DONE after the write with k = count−1.
- **Store rule:**
  - If c ≥ 2^WIDTH: set `ovf`; write 2^WIDTH−1 if `sat`, else c mod 2^WIDTH.
  - Otherwise write c.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Ignored requests:** `start` is ignored outside IDLE. Latched inputs do not change during a run.
- **Unwritten entries:** entries at k ≥ count keep their previous contents.
- **Read port:**
  - `rd_data` ← table[`rd_addr`] every cycle.
  - `rd_addr` ≥ DEPTH returns 0.
  - A read of the address being written in the same cycle returns the old word.

## Timing
- **Reset (async):**
  - state=IDLE; `busy`=0, `done`=0, `ovf`=0, `rd_data`=0.
  - All table entries = 0.
  - Counters n, c, a, b = initial values.
- **Run latency:** `start` sampled at edge T.
  - `busy` is high in cycles T+1 … T+first+count.
  - `done` is high in cycle T+1+first+count.
  - Earliest next accepted `start` is the edge after the `done` cycle.
- **Write visibility:** a FILL write at edge E is visible on `rd_data` one cycle after `rd_addr` is presented at or after E+1. Read latency is 1 cycle.
- **Reset mid-run:**
  - Immediate IDLE.
  - No `done` pulse.
  - Table is cleared.
  - Partial results are lost.
- **Simultaneous events:** `start` in the DONE cycle is ignored.

## Test plan
- **Basic run from zero:** WIDTH=8, DEPTH=16, start first=0 count=6 sat=0 → table[0..5] = 0, 1, 8, 27, 64, 125. `busy` for 6 cycles; `done` at T+7; `ovf`=0; table[6] = 0.
- **Offset run, saturate:** first=5 count=3 sat=1 → table[0..2] = 125, 216, 255; `ovf`=1; `done` at T+9.
- **Offset run, wrap:** same as above with sat=0 → table[2] = 87 (343 mod 256); `ovf`=1. A following run with first=0 count=1 clears `ovf` → table[0] = 0.
- **Clamp and read edges:**
  - count=20 → 16 writes, table[15] = 3375 mod 256 = 47, `done` at T+17.
  - count=0, first=0 → `done` at T+1, table unchanged.
  - `rd_addr`=15 returns 47.
- **Ignored start:** `start` pulsed while `busy` and in the DONE cycle → no effect on results or timing.
- **Reset mid-run:** `rst_n` low during FILL → `busy`/`done`/`ovf`/`rd_data` read 0 immediately; every address reads 0 afterwards; a fresh run then completes normally.
